// File: rtl/scan_sequencer.sv
// scan_sequencer: drives select/enable of a 3-to-8 one-hot decoder, stepping
// through the channels enabled in a latched mask in ascending order, holding
// each for dwell+1 cycles, in continuous or single-pass mode.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               pass_done
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic               mode_q, mode_d;
    logic               pass_done_q, pass_done_d;

    // Returns {found, index} of the lowest set bit of m.
    function automatic logic [3:0] lowest_bit(input logic [7:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // Returns {found, index} of the lowest set bit of m strictly above s.
    function automatic logic [3:0] next_bit(input logic [7:0] m, input logic [2:0] s);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(s))) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [3:0] start_pick;
    logic [3:0] next_pick;
    logic [3:0] wrap_pick;

    assign start_pick = lowest_bit(mask);
    assign next_pick  = next_bit(mask_q, sel_q);
    assign wrap_pick  = lowest_bit(mask_q);

    // State register and all output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            mask_q      <= 8'd0;
            mode_q      <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            pass_done_q <= pass_done_d;
        end
    end

    // Next-state logic: start latches settings, stop aborts, dwell expiry advances or wraps.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        pass_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop && start_pick[3]) begin
                    mask_d  = mask;
                    dwell_d = dwell;
                    mode_d  = mode;
                    sel_d   = start_pick[2:0];
                    cnt_d   = dwell;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (next_pick[3]) begin
                    sel_d = next_pick[2:0];
                    cnt_d = dwell_q;
                end else begin
                    pass_done_d = 1'b1;
                    if (!mode_q) begin
                        sel_d = wrap_pick[2:0];
                        cnt_d = dwell_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel       = sel_q;
    assign en        = (state_q == ACTIVE);
    assign busy      = (state_q == ACTIVE);
    assign pass_done = pass_done_q;

endmodule
